// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
package pipe_seq_pkg;

  // Sequencer FSM states; the encoding is exported on state_dbg
  typedef enum logic [2:0] {
    BOOT, RUN, STALL, DRAIN, PUSH_LO, PUSH_HI, VECTOR, RET_WAIT
  } seqState_t;

  // Fetch PC source select
  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_VEC = 2'b10,
    PCSEL_RET = 2'b11
  } pcSel_t;

  // Interrupt vector table indices
  localparam logic [2:0] VEC_RESET = 3'd0;
  localparam logic [2:0] VEC_INT   = 3'd1;

  // Control bundle driven to the pipeline each cycle
  typedef struct packed {
    pcSel_t     pcSel;
    logic [2:0] vecIndex;
    logic       fetchEn;
    logic       fdEn;
    logic       fdFlush;
    logic       deFlush;
    logic       pushPc;
    logic       pushHalf;
    logic       intAck;
  } seqCtrl_t;

  // Values presented while reset is held: nothing fetched, both buffers flushed
  localparam seqCtrl_t CTRL_RESET = '{
    pcSel: PCSEL_SEQ, vecIndex: VEC_RESET, fetchEn: 1'b0, fdEn: 1'b0,
    fdFlush: 1'b1, deFlush: 1'b1, pushPc: 1'b0, pushHalf: 1'b0, intAck: 1'b0
  };

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_cnt.sv
// Loadable down-counter with zero flag, shared by STALL, DRAIN and RET_WAIT
// (only one of those waits is ever active at a time).
module seq_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over decrement; decrement holds at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   count <= '0;
    else if (load)              count <= loadVal;
    else if (dec && !zero)      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Central sequencer for the 5-stage core (fetch/decode/execute/memory/WB).
// Handles taken-branch flushes, load-use stalls, reset boot, interrupt entry
// (drain, two-half PC push, vector load) and RTI return with one FSM.
// Optional macro PIPE_SEQ_PERF_EN enables the stall/flush perf counters.
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 3,
  parameter int LOAD_USE_STALL = 1,
  parameter int RET_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        is_rti,
  output logic [1:0]  pc_select,
  output logic [2:0]  vec_index,
  output logic        fetch_en,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        push_pc,
  output logic        push_half,
  output logic        int_ack,
  output logic [2:0]  state_dbg,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CW = $clog2(maxOf3(DRAIN_CYCLES, LOAD_USE_STALL, RET_LAT) + 1);

  seqState_t state, nextState;
  seqCtrl_t  ctrl;
  logic      intReqQ, intPending, clrPending;
  logic      cntLoad, cntDec, cntZero;
  logic [CW-1:0] cntLoadVal, cntVal;

  seq_down_counter #(.W(CW)) uCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .dec     (cntDec),
    .count   (cntVal),
    .zero    (cntZero)
  );

  // Interrupt edge latch; a new edge in the clearing cycle keeps it pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intReqQ    <= 1'b0;
      intPending <= 1'b0;
    end else begin
      intReqQ <= int_req;
      if (int_req && !intReqQ) intPending <= 1'b1;
      else if (clrPending)     intPending <= 1'b0;
    end
  end

  // Next-state, counter control and output decode (state plus RUN hazard terms)
  always_comb begin
    nextState     = state;
    cntLoad       = 1'b0;
    cntLoadVal    = '0;
    cntDec        = 1'b0;
    clrPending    = 1'b0;
    ctrl          = CTRL_RESET;
    ctrl.fdEn     = 1'b1;
    ctrl.fdFlush  = 1'b0;
    ctrl.deFlush  = 1'b0;
    case (state)
      BOOT: begin
        ctrl.pcSel    = PCSEL_VEC;
        ctrl.vecIndex = VEC_RESET;
        ctrl.fetchEn  = 1'b1;
        ctrl.fdEn     = 1'b0;
        ctrl.fdFlush  = 1'b1;
        ctrl.deFlush  = 1'b1;
        nextState     = RUN;
      end
      RUN: begin
        ctrl.fetchEn = 1'b1;
        if (branch_taken) begin
          ctrl.pcSel   = PCSEL_BR;
          ctrl.fdFlush = 1'b1;
          ctrl.deFlush = 1'b1;
        end else if (is_rti) begin
          ctrl.fetchEn = 1'b0;
          ctrl.fdFlush = 1'b1;
          cntLoad      = 1'b1;
          cntLoadVal   = CW'(RET_LAT - 1);
          nextState    = RET_WAIT;
        end else if (intPending) begin
          ctrl.fetchEn = 1'b0;
          ctrl.fdFlush = 1'b1;
          cntLoad      = 1'b1;
          cntLoadVal   = CW'(DRAIN_CYCLES - 1);
          nextState    = DRAIN;
        end else if (load_use) begin
          ctrl.fetchEn = 1'b0;
          ctrl.fdEn    = 1'b0;
          ctrl.deFlush = 1'b1;
          cntLoad      = 1'b1;
          cntLoadVal   = CW'(LOAD_USE_STALL - 1);
          if (LOAD_USE_STALL > 1) nextState = STALL;
        end
      end
      STALL: begin
        if (branch_taken) begin
          ctrl.pcSel   = PCSEL_BR;
          ctrl.fetchEn = 1'b1;
          ctrl.fdFlush = 1'b1;
          ctrl.deFlush = 1'b1;
          nextState    = RUN;
        end else begin
          // The RUN cycle that detected the hazard was the first bubble, so
          // leave once this decrement brings the counter to zero.
          ctrl.fetchEn = 1'b0;
          ctrl.fdEn    = 1'b0;
          ctrl.deFlush = 1'b1;
          cntDec       = 1'b1;
          if (cntVal <= CW'(1)) nextState = RUN;
        end
      end
      DRAIN: begin
        ctrl.fdFlush = 1'b1;
        if (branch_taken) begin
          // Let the target into the PC so it becomes the saved return address
          ctrl.pcSel   = PCSEL_BR;
          ctrl.fetchEn = 1'b1;
          ctrl.deFlush = 1'b1;
          cntLoad      = 1'b1;
          cntLoadVal   = CW'(DRAIN_CYCLES - 1);
        end else begin
          ctrl.fetchEn = 1'b0;
          cntDec       = 1'b1;
          if (cntZero) nextState = PUSH_LO;
        end
      end
      PUSH_LO: begin
        ctrl.fdFlush = 1'b1;
        ctrl.pushPc  = 1'b1;
        nextState    = PUSH_HI;
      end
      PUSH_HI: begin
        ctrl.fdFlush  = 1'b1;
        ctrl.pushPc   = 1'b1;
        ctrl.pushHalf = 1'b1;
        nextState     = VECTOR;
      end
      VECTOR: begin
        ctrl.pcSel    = PCSEL_VEC;
        ctrl.vecIndex = VEC_INT;
        ctrl.fetchEn  = 1'b1;
        ctrl.fdFlush  = 1'b1;
        ctrl.intAck   = 1'b1;
        clrPending    = 1'b1;
        nextState     = RUN;
      end
      RET_WAIT: begin
        ctrl.fdFlush = 1'b1;
        if (cntZero) begin
          ctrl.pcSel   = PCSEL_RET;
          ctrl.fetchEn = 1'b1;
          nextState    = RUN;
        end else begin
          cntDec = 1'b1;
        end
      end
      default: nextState = BOOT;
    endcase
    if (!rst) ctrl = CTRL_RESET;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= nextState;
  end

  assign pc_select = ctrl.pcSel;
  assign vec_index = ctrl.vecIndex;
  assign fetch_en  = ctrl.fetchEn;
  assign fd_en     = ctrl.fdEn;
  assign fd_flush  = ctrl.fdFlush;
  assign de_flush  = ctrl.deFlush;
  assign push_pc   = ctrl.pushPc;
  assign push_half = ctrl.pushHalf;
  assign int_ack   = ctrl.intAck;
  assign state_dbg = state;

`ifdef PIPE_SEQ_PERF_EN
  logic [15:0] stallCntQ, flushCntQ;

  // Saturating perf counters for fetch stalls and D/E flushes after boot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else if (state != BOOT) begin
      if (!ctrl.fetchEn && stallCntQ != 16'hFFFF) stallCntQ <= stallCntQ + 16'd1;
      if (ctrl.deFlush  && flushCntQ != 16'hFFFF) flushCntQ <= flushCntQ + 16'd1;
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed scenarios plus a random
// load-use/branch run checked against a cycle-count reference model.
module tb_pipe_seq_ctrl;

  localparam int DC = 3;
  localparam int LU = 2;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic int_req = 1'b0, load_use = 1'b0, branch_taken = 1'b0, is_rti = 1'b0;
  logic [1:0]  pc_select;
  logic [2:0]  vec_index, state_dbg;
  logic        fetch_en, fd_en, fd_flush, de_flush, push_pc, push_half, int_ack;
  logic [15:0] stall_cnt, flush_cnt;

  int nTests = 0;
  int nFail  = 0;

  pipe_seq_ctrl #(.DRAIN_CYCLES(DC), .LOAD_USE_STALL(LU), .RET_LAT(RL)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .load_use(load_use),
    .branch_taken(branch_taken), .is_rti(is_rti), .pc_select(pc_select),
    .vec_index(vec_index), .fetch_en(fetch_en), .fd_en(fd_en),
    .fd_flush(fd_flush), .de_flush(de_flush), .push_pc(push_pc),
    .push_half(push_half), .int_ack(int_ack), .state_dbg(state_dbg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Output bundle: {pc[11:10], vec[9:7], fe[6], fden[5], fdfl[4], defl[3], push[2], half[1], ack[0]}
  function automatic logic [11:0] ex(input logic [1:0] pc, input logic [2:0] v,
      input logic fe, input logic fden, input logic fdfl, input logic defl,
      input logic pp, input logic ph, input logic ack);
    return {pc, v, fe, fden, fdfl, defl, pp, ph, ack};
  endfunction

  function automatic logic [11:0] obs();
    return {pc_select, vec_index, fetch_en, fd_en, fd_flush, de_flush, push_pc, push_half, int_ack};
  endfunction

  // Masks select only the fields the sequencer defines in each situation
  localparam logic [11:0] M_ALL    = 12'hFFF;
  localparam logic [11:0] M_NOVEC  = 12'hC7F;
  localparam logic [11:0] M_CORE   = 12'hC5F;
  localparam logic [11:0] M_NOFDEN = 12'hFDF;

  logic [11:0] RSTV, BOOTV, RUNV, STALLV, BRV, HOLDV, DRBV, PLOV, PHIV, VECV, RETV;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_ALL) !== (RSTV & M_ALL)) begin
      nFail++; $display("FAIL reset_outs: got %h want %h", obs(), RSTV);
    end
    nTests++;
    if (state_dbg !== 3'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      nFail++; $display("FAIL reset_state: state %0d stall %0d flush %0d want 0/0/0", state_dbg, stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOFDEN) !== (BOOTV & M_NOFDEN)) begin
      nFail++; $display("FAIL boot_cycle: got %h want %h", obs(), BOOTV);
    end
    tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_ALL) !== (RUNV & M_ALL)) begin
      nFail++; $display("FAIL run_after_boot: got %h want %h", obs(), RUNV);
    end
    tick();
  endtask

  task automatic test_load_use();
    load_use = 1'b1;
    for (int i = 0; i < LU; i++) begin
      @(negedge clk);
      nTests++;
      if ((obs() & M_NOVEC) !== (STALLV & M_NOVEC)) begin
        nFail++; $display("FAIL lu_stall%0d: got %h want %h", i, obs(), STALLV);
      end
      tick();
      load_use = 1'b0;
    end
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
      nFail++; $display("FAIL lu_resume: got %h want %h", obs(), RUNV);
    end
    tick();
  endtask

  task automatic test_branch_over_load_use();
    branch_taken = 1'b1; load_use = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (BRV & M_NOVEC)) begin
      nFail++; $display("FAIL br_over_lu: got %h want %h", obs(), BRV);
    end
    tick();
    branch_taken = 1'b0; load_use = 1'b0;
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
      nFail++; $display("FAIL br_no_stall: got %h want %h", obs(), RUNV);
    end
    tick();
  endtask

  task automatic test_interrupt();
    int_req = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
      nFail++; $display("FAIL int_edge_cycle: got %h want %h", obs(), RUNV);
    end
    tick();
    // cycles 1..7 after the edge: detect, DC drains, push lo, push hi, vector
    for (int i = 0; i < 1 + DC; i++) begin
      @(negedge clk);
      nTests++;
      if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
        nFail++; $display("FAIL int_drain%0d: got %h want %h", i, obs(), HOLDV);
      end
      tick();
    end
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (PLOV & M_CORE)) begin
      nFail++; $display("FAIL int_push_lo: got %h want %h", obs(), PLOV);
    end
    tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (PHIV & M_CORE)) begin
      nFail++; $display("FAIL int_push_hi: got %h want %h", obs(), PHIV);
    end
    tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOFDEN) !== (VECV & M_NOFDEN)) begin
      nFail++; $display("FAIL int_vector: got %h want %h", obs(), VECV);
    end
    tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
      nFail++; $display("FAIL int_resume: got %h want %h", obs(), RUNV);
    end
    tick();
    int_req = 1'b0;
    tick();
  endtask

  task automatic test_drain_branch();
    int_req = 1'b1;
    tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
      nFail++; $display("FAIL drb_detect: got %h want %h", obs(), HOLDV);
    end
    tick();
    branch_taken = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (DRBV & M_CORE)) begin
      nFail++; $display("FAIL drb_branch: got %h want %h", obs(), DRBV);
    end
    tick();
    branch_taken = 1'b0;
    // branch reloads the drain, so a full DC drain cycles follow
    for (int i = 0; i < DC; i++) begin
      @(negedge clk);
      nTests++;
      if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
        nFail++; $display("FAIL drb_drain%0d: got %h want %h", i, obs(), HOLDV);
      end
      tick();
    end
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (PLOV & M_CORE)) begin
      nFail++; $display("FAIL drb_push_lo: got %h want %h", obs(), PLOV);
    end
    tick(); tick(); tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
      nFail++; $display("FAIL drb_resume: got %h want %h", obs(), RUNV);
    end
    int_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_rti();
    logic seen;
    is_rti = 1'b1; int_req = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
      nFail++; $display("FAIL rti_decode: got %h want %h", obs(), HOLDV);
    end
    tick();
    is_rti = 1'b0;
    for (int k = 1; k < RL; k++) begin
      @(negedge clk);
      nTests++;
      if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
        nFail++; $display("FAIL rti_wait%0d: got %h want %h", k, obs(), HOLDV);
      end
      tick();
    end
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (RETV & M_CORE)) begin
      nFail++; $display("FAIL rti_pop: got %h want %h", obs(), RETV);
    end
    tick();
    // latched interrupt is taken on the first RUN cycle after the return
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (HOLDV & M_CORE)) begin
      nFail++; $display("FAIL rti_then_int: got %h want %h", obs(), HOLDV);
    end
    tick();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (int_ack) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    nTests++;
    if (seen !== 1'b1) begin
      nFail++; $display("FAIL rti_int_ack: got %b want 1 within 20 cycles", seen);
    end
    int_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int rem, expStall, expFlush;
    logic lu, br;
    logic [11:0] e;
    logic [15:0] s0, f0;
    rem = 0; expStall = 0; expFlush = 0;
    s0 = stall_cnt; f0 = flush_cnt;
    for (int c = 0; c < 300 + LU; c++) begin
      lu = (c < 300) && ($urandom_range(0, 3) == 0);
      br = (c < 300) && ($urandom_range(0, 5) == 0);
      load_use = lu; branch_taken = br;
      if (br)           begin e = BRV;    rem = 0;      end
      else if (rem > 0) begin e = STALLV; rem--;        end
      else if (lu)      begin e = STALLV; rem = LU - 1; end
      else                    e = RUNV;
      if (!e[6]) expStall++;
      if (e[3])  expFlush++;
      @(negedge clk);
      nTests++;
      if ((obs() & M_NOVEC) !== (e & M_NOVEC)) begin
        nFail++; $display("FAIL rand_c%0d: got %h want %h (lu %b br %b)", c, obs(), e, lu, br);
      end
      tick();
    end
    load_use = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
`ifdef PIPE_SEQ_PERF_EN
    nTests++;
    if (32'(stall_cnt - s0) !== 32'(expStall)) begin
      nFail++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt - s0, expStall);
    end
    nTests++;
    if (32'(flush_cnt - f0) !== 32'(expFlush)) begin
      nFail++; $display("FAIL rand_flush_cnt: got %0d want %0d", flush_cnt - f0, expFlush);
    end
`else
    nTests++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s0 !== 16'd0 || f0 !== 16'd0) begin
      nFail++; $display("FAIL perf_disabled: got %0d/%0d want 0/0 (model %0d/%0d)", stall_cnt, flush_cnt, expStall, expFlush);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_push();
    int_req = 1'b1;
    tick();
    repeat (1 + DC + 1) tick();
    @(negedge clk);
    nTests++;
    if ((obs() & M_CORE) !== (PHIV & M_CORE)) begin
      nFail++; $display("FAIL mph_push_hi: got %h want %h", obs(), PHIV);
    end
    #2 rst = 1'b0;
    #1;
    nTests++;
    if ((obs() & M_ALL) !== (RSTV & M_ALL)) begin
      nFail++; $display("FAIL mph_async: got %h want %h", obs(), RSTV);
    end
    int_req = 1'b0;
    tick(); tick();
    @(negedge clk);
    nTests++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      nFail++; $display("FAIL mph_cnt_zero: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ((obs() & M_NOFDEN) !== (BOOTV & M_NOFDEN)) begin
      nFail++; $display("FAIL mph_boot: got %h want %h", obs(), BOOTV);
    end
    tick();
    // the half-finished interrupt entry must not resume
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nTests++;
      if ((obs() & M_NOVEC) !== (RUNV & M_NOVEC)) begin
        nFail++; $display("FAIL mph_run%0d: got %h want %h", i, obs(), RUNV);
      end
      tick();
    end
  endtask

  initial begin
    RSTV  = ex(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    BOOTV = ex(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    RUNV  = ex(2'b00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    STALLV= ex(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    BRV   = ex(2'b01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    HOLDV = ex(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    DRBV  = ex(2'b01, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    PLOV  = ex(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    PHIV  = ex(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    VECV  = ex(2'b10, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    RETV  = ex(2'b11, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_interrupt();
    test_drain_branch();
    test_rti();
    test_random();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Central sequencer for the 5-stage core: fetch, decode, execute, memory and write-back.
- Generates the fetch `pc_select` and `vec_index`, the per-buffer enables and flushes, and the memory-stage PC-push strobe.
- Resolves control hazards (taken branch), data hazards (load-use) and control transfers (reset boot, interrupt entry, RTI return) using one FSM.

Parameters:
- DRAIN_CYCLES, 3: cycles of NOP injection before the interrupt PC push; legal range ≥1.
- LOAD_USE_STALL, 1: bubbles inserted per load-use hazard; legal range ≥1.
- RET_LAT, 2: cycles between RTI in decode and the popped PC being valid at fetch.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- int_req  in  1  external interrupt request, level input, edge-detected internally.
- load_use  in  1  hazard unit: decode instruction sources the Rdst of a load in execute.
- branch_taken  in  1  execute resolved a taken branch/jump/call.
- is_rti  in  1  RTI/RET decoded in decode stage.
- pc_select  out  2  00 PC+1, 01 branch target, 10 vector (IVT[vec_index]), 11 popped return PC.
- vec_index  out  3  0 reset vector, 1 interrupt vector.
- fetch_en  out  1  PC register update enable.
- fd_en  out  1  fetch/decode buffer enable.
- fd_flush  out  1  fetch/decode buffer loads NOP.
- de_flush  out  1  decode/execute buffer loads NOP.
- push_pc  out  1  memory stage pushes saved PC (i_isPushPc).
- push_half  out  1  0 = low 16 bits, 1 = high 16 bits.
- int_ack  out  1  one-cycle pulse on interrupt vector load.
- state_dbg  out  3  current FSM state encoding.
- stall_cnt  out  16  performance counter, see Optional Feature.
- flush_cnt  out  16  performance counter, see Optional Feature.

Behaviour:
- While rst=0:
  - State is BOOT, counters are 0 and `int_pending` is 0.
  - fetch_en=0, fd_en=0, fd_flush=1, de_flush=1, pc_select=00, vec_index=0, push_pc=0, push_half=0, int_ack=0.
- All outputs are Moore/registered-state decodes plus combinational RUN-state hazard terms; there is no added latency beyond that stated.
- Interrupt edge detect:
  - `int_pending` sets on an int_req 0→1 edge and clears in VECTOR.
  - An edge in the same cycle as the clear wins, so pending stays 1.
- BOOT (1 cycle): pc_select=10, vec_index=0, fetch_en=1, fd_flush=1, de_flush=1. Next state is RUN.
- RUN, default: fetch_en=1, fd_en=1, pc_select=00, no flush. Priority is highest first:
  1. branch_taken: pc_select=01, fd_flush=1, de_flush=1; stay in RUN. Overrides load_use and defers a pending interrupt by one cycle.
  2. is_rti: fetch_en=0, fd_flush=1, load counter RET_LAT-1, go to RET_WAIT.
  3. int_pending: fetch_en=0, fd_flush=1, load counter DRAIN_CYCLES-1, go to DRAIN.
  4. load_use:
     - fetch_en=0, fd_en=0, de_flush=1, load stall counter LOAD_USE_STALL-1.
     - If the counter ≠0, go to STALL; otherwise stay in RUN.
- STALL:
  - Same outputs as a load_use stall; the counter decrements each cycle.
  - At 0, go to RUN.
  - A branch_taken here behaves as in RUN and exits to RUN.
- DRAIN:
  - fetch_en=0, fd_flush=1; downstream stages keep running.
  - The counter decrements each cycle; at 0, go to PUSH_LO.
  - If branch_taken: pc_select=01, fetch_en=1 for that cycle so the saved PC is the target, de_flush=1, and the counter reloads.
- PUSH_LO: push_pc=1, push_half=0, fetch_en=0, fd_flush=1. Next state is PUSH_HI.
- PUSH_HI: push_pc=1, push_half=1, fetch_en=0, fd_flush=1. Next state is VECTOR.
- VECTOR: pc_select=10, vec_index=1, fetch_en=1, fd_flush=1, int_ack=1; clear `int_pending`. Next state is RUN.
- RET_WAIT:
  - fetch_en=0, fd_flush=1; the counter decrements each cycle.
  - At 0: pc_select=11, fetch_en=1, go to RUN.
- Interrupt masking: interrupts are not taken in DRAIN, PUSH_*, VECTOR or RET_WAIT; they stay latched.
- Inputs in non-RUN states: load_use and is_rti are ignored outside RUN (the FSM already flushes).
- Reset mid-operation: asynchronous reset returns to BOOT from any state, including mid-push; a half-pushed PC is discarded.
- Counter width: $clog2(max(DRAIN_CYCLES,LOAD_USE_STALL,RET_LAT)+1).

Optional Feature:
- Macro: PIPE_SEQ_PERF_EN.
- When defined:
  - stall_cnt increments every cycle fetch_en=0 outside BOOT.
  - flush_cnt increments every cycle de_flush=1 outside BOOT.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared by rst.
- When undefined: both ports are driven 16'd0 and no counter flops are inferred.

Decomposition:
- Package pipe_seq_pkg:
  - State enum: BOOT, RUN, STALL, DRAIN, PUSH_LO, PUSH_HI, VECTOR, RET_WAIT.
  - pc_select encodings: PCSEL_SEQ, PCSEL_BR, PCSEL_VEC, PCSEL_RET.
  - Vector index constants: VEC_RESET, VEC_INT.
- Sub-module seq_down_counter: a loadable down-counter with a zero flag. It is shared by STALL, DRAIN and RET_WAIT, since only one is active at a time.

Test Plan:
- Reset release:
  - Stimulus: rst 0→1.
  - Required response: one BOOT cycle with pc_select=10, vec_index=0, fetch_en=1; next cycle RUN with pc_select=00, fd_en=1.
- Load-use stall:
  - Stimulus: load_use=1 for 1 cycle, LOAD_USE_STALL=2.
  - Required response: exactly 2 cycles of fetch_en=0, fd_en=0, de_flush=1, then normal RUN.
- Branch over load-use:
  - Stimulus: branch_taken=1 and load_use=1 in the same cycle.
  - Required response: pc_select=01, fd_flush=1, de_flush=1, no stall cycle.
- Interrupt entry:
  - Stimulus: int_req rising edge, DRAIN_CYCLES=3.
  - Required response:
    - 3 DRAIN cycles.
    - push_pc=1 with push_half 0 then 1.
    - VECTOR with pc_select=10, vec_index=1, int_ack pulse.
    - RUN; 7 cycles total from the edge.
- RTI:
  - Stimulus: is_rti=1 with int_req edge in the same cycle, RET_LAT=2.
  - Required response:
    - RET_WAIT for 2 cycles, then pc_select=11.
    - Interrupt stays pending and enters DRAIN on the following RUN cycle.
- Asynchronous reset mid-push:
  - Stimulus: rst low during PUSH_HI.
  - Required response: outputs immediately take reset values with push_pc=0; BOOT after release; with PIPE_SEQ_PERF_EN defined, counters read 0.
